// File: rtl/map_collision_reader.sv
// map_collision_reader
//   Reader-side companion to the tile-map writer. On each start pulse it probes
//   the live tile map at the four corners of the player's bounding box and at its
//   centre. It then reports the highest-priority collision tile, whether any corner
//   is solid, the centre tile row/column, and whether the centre tile is
//   interactive. The corners are read one per cycle, so only one mapData mux is
//   needed.
//
//   Optional feature: define MAPREAD_DEBUG_EN to add dbgCornerTiles and
//   dbgProbeCount. Without it, neither port nor the counter exists.
//
// Ports
//   Clk            in   system clock
//   reset          in   synchronous, active-high
//   start          in   probe request, sampled only in IDLE (and not on done)
//   playerX/Y      in   player box top-left, pixels (10 bit)
//   mapData        in   live map, [0:399][4:0], index = row*MAP_COLS + col
//   busy           out  high from C0 through RESOLVE
//   done           out  one-cycle pulse, results valid from this cycle
//   collisionTile  out  ladder 7, else first solid corner (TL,TR,BL,BR), else 0
//   blocked        out  any corner solid
//   playerCurrRow  out  centre tile row, clamped to MAP_ROWS-1
//   playerCurrCol  out  centre tile column, clamped to MAP_COLS-1
//   enemyOverlap   out  pulses with done when the centre tile is interactive
//   dbgCornerTiles out  {TL,TR,BL,BR,CTR} at the last done   (MAPREAD_DEBUG_EN)
//   dbgProbeCount  out  completed probes, wraps               (MAPREAD_DEBUG_EN)
//
// state   | meaning
// IDLE    | waiting for start; position latched on acceptance
// C0..C3  | reading TL, TR, BL, BR corner tiles
// CTR     | reading the centre tile
// RESOLVE | results computed and registered, done pulsed on exit
module map_collision_reader #(
    parameter int TILE_SHIFT  = 4,
    parameter int MAP_COLS    = 20,
    parameter int MAP_ROWS    = 20,
    parameter int PLAYER_SIZE = 16
) (
    input  logic                                 Clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [9:0]                           playerX,
    input  logic [9:0]                           playerY,
    input  logic [0:MAP_ROWS*MAP_COLS-1][4:0]    mapData,
    output logic                                 busy,
    output logic                                 done,
    output logic [4:0]                           collisionTile,
    output logic                                 blocked,
    output logic [4:0]                           playerCurrRow,
    output logic [4:0]                           playerCurrCol,
    output logic                                 enemyOverlap
`ifdef MAPREAD_DEBUG_EN
    ,
    output logic [24:0]                          dbgCornerTiles,
    output logic [15:0]                          dbgProbeCount
`endif
);

    localparam int         N_TILES = MAP_ROWS * MAP_COLS;
    localparam int         IDX_W   = $clog2(N_TILES);
    localparam logic [10:0] FAR    = 11'(PLAYER_SIZE - 1);
    localparam logic [10:0] HALF   = 11'(PLAYER_SIZE / 2);
    localparam logic [4:0]  BORDER = 5'd5;

    typedef enum logic [2:0] {IDLE, C0, C1, C2, C3, CTR, RESOLVE} state_t;

    state_t     state;
    logic [9:0] x_q, y_q;
    logic [4:0] tl_q, tr_q, bl_q, br_q, ctr_q;

    function automatic logic is_solid(input logic [4:0] code);
        return (code == 5'd1) || (code == 5'd5) || (code == 5'd6);
    endfunction

    function automatic logic is_interactive(input logic [4:0] code);
        return (code == 5'd3) || (code == 5'd4) || (code == 5'd10) ||
               (code == 5'd11) || (code == 5'd12) || (code == 5'd13);
    endfunction

    // Probe point for the current state; sums are 11 bits, so they never wrap.
    logic [10:0] probe_x, probe_y;
    always_comb begin
        probe_x = {1'b0, x_q};
        probe_y = {1'b0, y_q};
        case (state)
            C1:  probe_x = {1'b0, x_q} + FAR;
            C2:  probe_y = {1'b0, y_q} + FAR;
            C3:  begin
                probe_x = {1'b0, x_q} + FAR;
                probe_y = {1'b0, y_q} + FAR;
            end
            CTR: begin
                probe_x = {1'b0, x_q} + HALF;
                probe_y = {1'b0, y_q} + HALF;
            end
            default: ;
        endcase
    end

    logic [10:0]      probe_col, probe_row;
    logic             probe_in_range;
    logic [IDX_W-1:0] probe_idx;
    logic [4:0]       probe_tile;

    assign probe_col      = probe_x >> TILE_SHIFT;
    assign probe_row      = probe_y >> TILE_SHIFT;
    assign probe_in_range = (probe_col < 11'(MAP_COLS)) && (probe_row < 11'(MAP_ROWS));
    // Index forced to 0 off-map so the mux never sees an address past the map.
    assign probe_idx      = probe_in_range ? IDX_W'(probe_row * 11'(MAP_COLS) + probe_col) : '0;
    assign probe_tile     = probe_in_range ? mapData[probe_idx] : BORDER;

    // Centre row/column, clamped to the last row/column when off-map.
    logic [10:0] ctr_col_full, ctr_row_full;
    logic [4:0]  ctr_col, ctr_row;
    assign ctr_col_full = ({1'b0, x_q} + HALF) >> TILE_SHIFT;
    assign ctr_row_full = ({1'b0, y_q} + HALF) >> TILE_SHIFT;
    assign ctr_col = (ctr_col_full >= 11'(MAP_COLS)) ? 5'(MAP_COLS - 1) : ctr_col_full[4:0];
    assign ctr_row = (ctr_row_full >= 11'(MAP_ROWS)) ? 5'(MAP_ROWS - 1) : ctr_row_full[4:0];

    logic       any_ladder, any_solid;
    logic [4:0] resolved_tile;
    always_comb begin
        any_ladder = (tl_q == 5'd7) || (tr_q == 5'd7) || (bl_q == 5'd7) || (br_q == 5'd7);
        any_solid  = is_solid(tl_q) || is_solid(tr_q) || is_solid(bl_q) || is_solid(br_q);
        if (any_ladder)        resolved_tile = 5'd7;
        else if (is_solid(tl_q)) resolved_tile = tl_q;
        else if (is_solid(tr_q)) resolved_tile = tr_q;
        else if (is_solid(bl_q)) resolved_tile = bl_q;
        else if (is_solid(br_q)) resolved_tile = br_q;
        else                   resolved_tile = 5'd0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state         <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            tl_q          <= '0;
            tr_q          <= '0;
            bl_q          <= '0;
            br_q          <= '0;
            ctr_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            collisionTile <= '0;
            blocked       <= 1'b0;
            playerCurrRow <= '0;
            playerCurrCol <= '0;
            enemyOverlap  <= 1'b0;
        end else begin
            done         <= 1'b0;
            enemyOverlap <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with done belongs to the finished probe.
                    if (start && !done) begin
                        x_q   <= playerX;
                        y_q   <= playerY;
                        busy  <= 1'b1;
                        state <= C0;
                    end
                end
                C0: begin
                    tl_q  <= probe_tile;
                    state <= C1;
                end
                C1: begin
                    tr_q  <= probe_tile;
                    state <= C2;
                end
                C2: begin
                    bl_q  <= probe_tile;
                    state <= C3;
                end
                C3: begin
                    br_q  <= probe_tile;
                    state <= CTR;
                end
                CTR: begin
                    ctr_q <= probe_tile;
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    collisionTile <= resolved_tile;
                    blocked       <= any_solid;
                    playerCurrRow <= ctr_row;
                    playerCurrCol <= ctr_col;
                    enemyOverlap  <= is_interactive(ctr_q);
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MAPREAD_DEBUG_EN
    always_ff @(posedge Clk) begin
        if (reset) begin
            dbgCornerTiles <= '0;
            dbgProbeCount  <= '0;
        end else if (state == RESOLVE) begin
            dbgCornerTiles <= {tl_q, tr_q, bl_q, br_q, ctr_q};
            dbgProbeCount  <= dbgProbeCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_map_collision_reader.sv
module tb_map_collision_reader;

    logic              Clk = 1'b0;
    logic              reset;
    logic              start;
    logic [9:0]        playerX, playerY;
    logic [0:399][4:0] mapData;
    logic              busy, done, blocked, enemyOverlap;
    logic [4:0]        collisionTile, playerCurrRow, playerCurrCol;
`ifdef MAPREAD_DEBUG_EN
    logic [24:0]       dbgCornerTiles;
    logic [15:0]       dbgProbeCount;
`endif

    logic [4:0] map_m [400];
    always_comb begin
        for (int i = 0; i < 400; i++) mapData[i] = map_m[i];
    end

    map_collision_reader dut (
        .Clk(Clk), .reset(reset), .start(start),
        .playerX(playerX), .playerY(playerY), .mapData(mapData),
        .busy(busy), .done(done), .collisionTile(collisionTile), .blocked(blocked),
        .playerCurrRow(playerCurrRow), .playerCurrCol(playerCurrCol),
        .enemyOverlap(enemyOverlap)
`ifdef MAPREAD_DEBUG_EN
        , .dbgCornerTiles(dbgCornerTiles), .dbgProbeCount(dbgProbeCount)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: tile lookup by pixel with off-map reading as a solid border.
    function automatic int tile_at(input int px, input int py);
        int c, r;
        c = px / 16;
        r = py / 16;
        if (c >= 20 || r >= 20) return 5;
        return int'(map_m[r * 20 + c]);
    endfunction

    function automatic bit solid(input int t);
        return t == 1 || t == 5 || t == 6;
    endfunction

    task automatic model(input int x, input int y, output int et, output int eb,
                         output int er, output int ec, output int ee);
        int c[4];
        int ct;
        bit ladder;
        c[0] = tile_at(x, y);
        c[1] = tile_at(x + 15, y);
        c[2] = tile_at(x, y + 15);
        c[3] = tile_at(x + 15, y + 15);
        et = 0; eb = 0; ladder = 0;
        for (int k = 3; k >= 0; k--) begin
            if (c[k] == 7) ladder = 1;
            if (solid(c[k])) begin eb = 1; et = c[k]; end
        end
        if (ladder) et = 7;
        ct = tile_at(x + 8, y + 8);
        ee = (ct == 3 || ct == 4 || (ct >= 10 && ct <= 13)) ? 1 : 0;
        er = ((y + 8) / 16 > 19) ? 19 : (y + 8) / 16;
        ec = ((x + 8) / 16 > 19) ? 19 : (x + 8) / 16;
    endtask

    // Issues one start and returns the number of edges after the accepting edge
    // until done is seen (-1 if it never comes).
    task automatic do_probe(input int x, input int y, output int lat);
        playerX = 10'(x);
        playerY = 10'(y);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (done) begin lat = n; break; end
        end
    endtask

    typedef struct {
        int x; int y; int tile; int blk; int row; int col; int enm;
    } vec_t;
    vec_t vecs[9];

    int lat, et, eb, er, ec, ee, dcount, first;
`ifdef MAPREAD_DEBUG_EN
    int cnt_before;
`endif

    initial begin
        reset = 1'b1; start = 1'b0; playerX = '0; playerY = '0;
        for (int i = 0; i < 400; i++) map_m[i] = 5'd0;
        map_m[5*20+5]   = 5'd1;
        map_m[10*20+18] = 5'd7;
        map_m[9*20+8]   = 5'd3;
        map_m[12*20+2]  = 5'd6;
        map_m[12*20+3]  = 5'd7;
        map_m[15*20+10] = 5'd2;
        map_m[15*20+11] = 5'd1;
        map_m[16*20+10] = 5'd5;
        map_m[16*20+11] = 5'd6;
        map_m[3*20+15]  = 5'd13;

        vecs[0] = '{80,   72,   1, 1, 5,  5,  0};
        vecs[1] = '{288,  160,  7, 0, 10, 18, 0};
        vecs[2] = '{128,  144,  0, 0, 9,  8,  1};
        vecs[3] = '{312,  32,   5, 1, 2,  19, 0};
        vecs[4] = '{1023, 1023, 5, 1, 19, 19, 0};
        vecs[5] = '{0,    0,    0, 0, 0,  0,  0};
        vecs[6] = '{40,   192,  7, 1, 12, 3,  0};
        vecs[7] = '{168,  248,  1, 1, 16, 11, 0};
        vecs[8] = '{232,  40,   0, 0, 3,  15, 1};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tile", collisionTile, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_row", playerCurrRow, 0);
        chk("rst_col", playerCurrCol, 0);
        chk("rst_enemy", enemyOverlap, 0);
        reset = 1'b0;
        @(posedge Clk); #1;

        // Directed table
        for (int v = 0; v < 9; v++) begin
            do_probe(vecs[v].x, vecs[v].y, lat);
            chk("tbl_latency", lat, 6);
            chk("tbl_tile", collisionTile, vecs[v].tile);
            chk("tbl_blocked", blocked, vecs[v].blk);
            chk("tbl_row", playerCurrRow, vecs[v].row);
            chk("tbl_col", playerCurrCol, vecs[v].col);
            chk("tbl_enemy", enemyOverlap, vecs[v].enm);
            chk("tbl_busy_at_done", busy, 0);
            @(posedge Clk); #1;
            chk("tbl_done_pulse", done, 0);
            chk("tbl_enemy_pulse", enemyOverlap, 0);
            chk("tbl_tile_hold", collisionTile, vecs[v].tile);
        end

        // start during a probe (at E2) is ignored: exactly one done
`ifdef MAPREAD_DEBUG_EN
        cnt_before = int'(dbgProbeCount);
`endif
        playerX = 10'd80; playerY = 10'd72; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        @(posedge Clk); #1; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        dcount = 0; first = -1;
        for (int n = 1; n <= 15; n++) begin
            @(posedge Clk); #1;
            if (done) begin dcount++; if (first < 0) first = n; end
        end
        chk("e2_done_count", dcount, 1);
        chk("e2_done_edge", first, 4);
        chk("e2_busy_idle", busy, 0);
`ifdef MAPREAD_DEBUG_EN
        chk("dbg_count_inc", int'(dbgProbeCount), cnt_before + 1);
        chk("dbg_corners", dbgCornerTiles, {5'd0, 5'd0, 5'd1, 5'd1, 5'd1});
`endif

        // start in the done cycle is ignored
        do_probe(128, 144, lat);
        chk("dc_latency", lat, 6);
        start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        chk("dc_busy_ignored", busy, 0);
        @(posedge Clk); #1;
        chk("dc_still_idle", busy, 0);
        chk("dc_no_done", done, 0);

        // reset while in C2: no done, outputs cleared, then normal probe
        do_probe(80, 72, lat);
        @(posedge Clk); #1;
        playerX = 10'd288; playerY = 10'd160; start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        @(posedge Clk);
        @(posedge Clk); #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        chk("rc2_busy", busy, 0);
        chk("rc2_tile", collisionTile, 0);
        chk("rc2_blocked", blocked, 0);
        chk("rc2_row", playerCurrRow, 0);
        chk("rc2_col", playerCurrCol, 0);
        dcount = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge Clk); #1;
            if (done) dcount++;
        end
        chk("rc2_no_done", dcount, 0);
`ifdef MAPREAD_DEBUG_EN
        chk("rc2_dbg_count", dbgProbeCount, 0);
`endif
        do_probe(288, 160, lat);
        chk("rc2_next_latency", lat, 6);
        chk("rc2_next_tile", collisionTile, 7);
        chk("rc2_next_blocked", blocked, 0);
        @(posedge Clk); #1;

        // Randomized maps and positions against the reference model
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < 400; i++)
                map_m[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                       : 5'($urandom_range(0, 13));
            if ($urandom_range(0, 7) == 0) begin
                playerX = 10'($urandom_range(0, 1023));
                playerY = 10'($urandom_range(0, 1023));
            end else begin
                playerX = 10'($urandom_range(0, 330));
                playerY = 10'($urandom_range(0, 330));
            end
            model(int'(playerX), int'(playerY), et, eb, er, ec, ee);
            do_probe(int'(playerX), int'(playerY), lat);
            chk("rnd_latency", lat, 6);
            chk("rnd_tile", collisionTile, et);
            chk("rnd_blocked", blocked, eb);
            chk("rnd_row", playerCurrRow, er);
            chk("rnd_col", playerCurrCol, ec);
            chk("rnd_enemy", enemyOverlap, ee);
            @(posedge Clk); #1;
            chk("rnd_enemy_pulse", enemyOverlap, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
